tblink_rpc_invoke_arb: RTL
==========================

TBLINK_RPC_INVOKE_ARB -- requirements
Module: tblink_rpc_invoke_arb

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters; METHOD_W, default 8, method-id width; PARAM_W, default 64, packed-params/return width; NTAG, default 4, max outstanding blocking invokes (power of 2, TAG_W=log2(NTAG)).
REQ-002 Ports SHALL be, in order:
  clock  in  1  sole clock, rising edge
  reset_n  in  1  asynchronous active-low reset
  req_valid  in  NREQ  per-requester invoke request
  req_ready  out  NREQ  per-requester accept
  req_blocking  in  NREQ  1 = blocking method (response expected)
  req_method  in  NREQ*METHOD_W  method ids, requester i at slice i
  req_params  in  NREQ*PARAM_W  packed params, requester i at slice i
  out_valid  out  1  invoke toward endpoint
  out_ready  in  1  endpoint accept
  out_src  out  log2(NREQ)  originating requester
  out_tag  out  TAG_W  tag (blocking only, else 0)
  out_blocking  out  1  blocking flag
  out_method  out  METHOD_W  method id
  out_params  out  PARAM_W  params
  in_rsp_valid  in  1  endpoint return (always accepted)
  in_rsp_tag  in  TAG_W  returning tag
  in_rsp_ret  in  PARAM_W  return value
  rsp_valid  out  NREQ  one-hot return pulse to requester
  rsp_ret  out  PARAM_W  return value, qualified by rsp_valid
  pending  out  NREQ  requester has blocking call outstanding
  err_unmatched  out  1  sticky: response to free tag
  busy  out  1  out_valid or any tag in use

Function
REQ-003 Output stage SHALL be a one-entry register with FSM EMPTY/FULL; EMPTY->FULL on accept, FULL->EMPTY on out_valid&&out_ready with no new accept, FULL->FULL when drain and accept coincide.
REQ-004 Eligible requester i: req_valid[i] && !pending[i] && (!req_blocking[i] || free tag exists).
REQ-005 Arbitration SHALL be round-robin among eligible requesters, starting one above last granted index; after reset the pointer starts at 0.
REQ-006 req_ready SHALL be one-hot (or zero) to the granted requester, asserted only when stage is EMPTY or draining this cycle; combinational from inputs and state.
REQ-007 Accept at edge N SHALL present out_* at N+1 (latency 1); out_* SHALL hold stable while out_valid && !out_ready.
REQ-008 Blocking accept SHALL allocate the lowest-numbered free tag, record src in the tag table, and set pending[src] at N+1.
REQ-009 Non-blocking accept SHALL allocate no tag, drive out_tag=0, and never produce rsp_valid.
REQ-010 in_rsp_valid with an in-use tag at edge N SHALL pulse rsp_valid[src] for exactly one cycle at N+1 with rsp_ret=in_rsp_ret, and free the tag and clear pending[src] at N+1.
REQ-011 in_rsp_valid with a free tag SHALL set err_unmatched (sticky until reset) and change no other state.
REQ-012 Tag freed and allocated in same cycle: freed tag SHALL NOT be reused until the following cycle; a requester whose pending clears at N+1 is eligible from N+1.
REQ-013 With all NTAG tags in use, blocking requests SHALL stall (req_ready=0) while non-blocking requests continue to be granted.
REQ-014 rsp_valid SHALL be zero whenever in_rsp_valid was zero the previous cycle.

Reset
REQ-015 reset_n low SHALL asynchronously clear: FSM to EMPTY, out_valid, out_* data to 0, tag table, pending, rsp_valid, rsp_ret, err_unmatched, RR pointer to 0.
REQ-016 Reset mid-operation SHALL discard outstanding tags and the held invoke; responses arriving after release for pre-reset tags SHALL set err_unmatched.

Structure
REQ-017 Package tblink_rpc_arb_pkg SHALL hold the output-stage state enum and a tag-entry struct (valid, src).
REQ-018 Round-robin arbiter SHALL be one sub-module, tblink_rpc_rr_arb (request vector in, one-hot grant out, pointer update on accept).

Verification
REQ-019 Requesters 0,2 assert blocking at once, out_ready=1 -> out_src 0 tag 0 then out_src 2 tag 1 on consecutive cycles; pending=4'b0101.
REQ-020 Return tag 1 ret=64'hDEAD -> next cycle rsp_valid=4'b0100, rsp_ret=64'hDEAD, pending=4'b0001.
REQ-021 Five blocking requests with NTAG=4, no responses -> four issued with tags 0..3, fifth stalls; a non-blocking request from a fifth-stalled-free requester issues with tag 0.
REQ-022 out_ready held 0 for 3 cycles with out_valid=1 -> out_* unchanged; req_ready=0 throughout.
REQ-023 in_rsp_tag=3 while tag 3 free -> err_unmatched=1, rsp_valid stays 0.
REQ-024 reset_n low with 2 tags outstanding -> pending=0, busy=0 asynchronously; later response tag 0 -> err_unmatched=1.

Source files
------------

// File: rtl/tblink_rpc_arb_pkg.sv
// Shared types for the tblink RPC invoke arbiter: output-stage state and tag-table entry.
package tblink_rpc_arb_pkg;

  // Widest requester index a tag entry can record; the top checks NREQ against it.
  localparam int SRC_MAX_W = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  typedef struct packed {
    logic                 valid;
    logic [SRC_MAX_W-1:0] src;
  } tag_entry_t;

endpackage

// File: rtl/tblink_rpc_rr_arb.sv
// Round-robin arbiter: one-hot grant searching upward from the pointer,
// pointer moves one past the winner when the grant is accepted.
module tblink_rpc_rr_arb #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic             accept,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr_q;

  // Pick the first requester at or above the pointer, wrapping around.
  always_comb begin : pick
    logic found;
    int   idx;
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = IDX_W'(idx);
      end
    end
  end

  // Advance the pointer past the requester that was actually accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of block order.
    if (!reset_n)
      ptr_q <= '0;
    else if (accept)
      ptr_q <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/tblink_rpc_invoke_arb.sv
// Invoke arbiter: round-robin selection of requesters into a one-entry output
// stage, tag allocation for blocking calls, and response routing by tag.
module tblink_rpc_invoke_arb
  import tblink_rpc_arb_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int METHOD_W = 8,
  parameter  int PARAM_W  = 64,
  parameter  int NTAG     = 4,
  localparam int TAG_W    = $clog2(NTAG),
  localparam int SRC_W    = $clog2(NREQ)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_blocking,
  input  logic [NREQ*METHOD_W-1:0] req_method,
  input  logic [NREQ*PARAM_W-1:0]  req_params,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SRC_W-1:0]         out_src,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_blocking,
  output logic [METHOD_W-1:0]      out_method,
  output logic [PARAM_W-1:0]       out_params,
  input  logic                     in_rsp_valid,
  input  logic [TAG_W-1:0]         in_rsp_tag,
  input  logic [PARAM_W-1:0]       in_rsp_ret,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [PARAM_W-1:0]       rsp_ret,
  output logic [NREQ-1:0]          pending,
  output logic                     err_unmatched,
  output logic                     busy
);

  stage_state_e     state_q, state_d;
  tag_entry_t       tag_tbl_q [NTAG];
  tag_entry_t       rsp_entry;
  logic [NTAG-1:0]  tag_used;
  logic [TAG_W-1:0] free_tag;
  logic             tag_avail;
  logic [NREQ-1:0]  eligible, grant;
  logic [SRC_W-1:0] grant_idx;
  logic             drain, can_accept, accept, alloc, rsp_hit;

  // Tag-table view: in-use mask, lowest free tag, and per-requester pending.
  always_comb begin
    pending  = '0;
    free_tag = '0;
    for (int t = 0; t < NTAG; t++) begin
      tag_used[t] = tag_tbl_q[t].valid;
      for (int i = 0; i < NREQ; i++)
        if (tag_tbl_q[t].valid && tag_tbl_q[t].src == SRC_MAX_W'(i)) pending[i] = 1'b1;
    end
    for (int t = NTAG - 1; t >= 0; t--)
      if (!tag_used[t]) free_tag = TAG_W'(t);
  end

  assign tag_avail = ~&tag_used;
  assign rsp_entry = tag_tbl_q[in_rsp_tag];
  assign rsp_hit   = in_rsp_valid && rsp_entry.valid;

  // A requester competes only if it has no call outstanding and, when blocking, a tag is free.
  always_comb begin
    for (int i = 0; i < NREQ; i++)
      eligible[i] = req_valid[i] && !pending[i] && (!req_blocking[i] || tag_avail);
  end

  tblink_rpc_rr_arb #(.N(NREQ)) u_rr_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (eligible),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign out_valid  = (state_q == ST_FULL);
  assign drain      = out_valid && out_ready;
  assign can_accept = (state_q == ST_EMPTY) || drain;
  assign req_ready  = can_accept ? grant : '0;
  assign accept     = |req_ready;
  assign alloc      = accept && req_blocking[grant_idx];
  assign busy       = out_valid || (|tag_used);

  // Output-stage next state: fill on accept, empty on drain without refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept)           state_d = ST_FULL;
      ST_FULL:  if (drain && !accept) state_d = ST_EMPTY;
      default:                        state_d = ST_EMPTY;
    endcase
  end

  // Output-stage state and held invoke; data only moves on accept, so it holds under backpressure.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_EMPTY;
      out_src      <= '0;
      out_tag      <= '0;
      out_blocking <= 1'b0;
      out_method   <= '0;
      out_params   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_src      <= grant_idx;
        out_tag      <= alloc ? free_tag : '0;
        out_blocking <= req_blocking[grant_idx];
        out_method   <= req_method[int'(grant_idx)*METHOD_W +: METHOD_W];
        out_params   <= req_params[int'(grant_idx)*PARAM_W +: PARAM_W];
      end
    end
  end

  // Tag table: allocate the lowest free tag on blocking accept, free a tag on a matching response.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: the tag table is reset because stale valid bits would corrupt pending and response routing; plain data stores need no reset.
    if (!reset_n) begin
      for (int t = 0; t < NTAG; t++) tag_tbl_q[t] <= '0;
    end else begin
      for (int t = 0; t < NTAG; t++) begin
        if (alloc && free_tag == TAG_W'(t)) begin
          tag_tbl_q[t].valid <= 1'b1;
          tag_tbl_q[t].src   <= SRC_MAX_W'(grant_idx);
        end else if (rsp_hit && in_rsp_tag == TAG_W'(t)) begin
          tag_tbl_q[t].valid <= 1'b0;
        end
      end
    end
  end

  // Route responses: one-cycle pulse to the owner, sticky error for a free tag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid     <= '0;
      rsp_ret       <= '0;
      err_unmatched <= 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        rsp_valid[i] <= rsp_hit && (rsp_entry.src == SRC_MAX_W'(i));
      if (rsp_hit) rsp_ret <= in_rsp_ret;
      if (in_rsp_valid && !rsp_entry.valid) err_unmatched <= 1'b1;
    end
  end

endmodule
